// File: rtl/discrete_audio_pkg.sv
// Shared types for the discrete audio chain: signed sample type, PCM player
// state encoding and the unsigned-byte to signed-sample conversion.
package discrete_audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } pcm_state_t;

  // 0x80 is silence; flipping the MSB recentres the byte around zero.
  function automatic sample_t u8_to_sample(input logic [7:0] b);
    return {b ^ 8'h80, 8'h00};
  endfunction

endpackage

// File: rtl/pcm_sample_player.sv
// Plays an 8-bit unsigned PCM region from an external ROM as a signed 16-bit
// stream, one sample per audio_clk_en, prefetching the next byte between enables.
//
// ROM handshake: rom_rd is a one-cycle request carrying rom_addr; the ROM answers
// with a single rom_valid/rom_data beat any number (>=1) of cycles later. At most
// one read is ever outstanding; a beat with no read outstanding is ignored.
module pcm_sample_player
  import discrete_audio_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  audio_clk_en,
  input  logic                  trigger,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_valid,
  input  logic [7:0]            rom_data,
  output sample_t               out,
  output logic                  playing,
  output logic                  done,
  output logic                  underrun,
  output pcm_state_t            state_dbg
);

  pcm_state_t            state_q, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, start_q, end_q;
  sample_t               buf_q;
  logic                  pending_q, discard_q, need_rd_q;
  logic                  rd_fire, ret, accept;
  logic                  play, finish, starve;

  // A restart suppresses any read in its own cycle so the old address never goes out.
  assign rd_fire   = (state_q == FETCH) && need_rd_q && !pending_q && !trigger;
  assign ret       = rom_valid && pending_q;
  assign accept    = ret && !discard_q && (state_q == FETCH) && !trigger;
  assign rom_rd    = rd_fire;
  assign rom_addr  = addr_q;
  assign state_dbg = state_q;

  always_comb begin
    state_n = state_q;
    play    = 1'b0;
    finish  = 1'b0;
    starve  = 1'b0;
    if (trigger) begin
      state_n = FETCH;
    end else begin
      case (state_q)
        IDLE: state_n = IDLE;
        FETCH: begin
          starve = audio_clk_en;
          if (accept) state_n = READY;
        end
        READY: begin
          if (audio_clk_en) begin
            play    = 1'b1;
            state_n = ((addr_q != end_q) || loop_en) ? FETCH : DRAIN;
          end
        end
        DRAIN: begin
          if (audio_clk_en) begin
            finish  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      buf_q     <= '0;
      out       <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      pending_q <= 1'b0;
      discard_q <= 1'b0;
      need_rd_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      underrun  <= starve;
      done      <= finish;
      pending_q <= rd_fire | (pending_q & ~ret);
      need_rd_q <= trigger | (play && (state_n == FETCH)) | (need_rd_q & ~rd_fire);
      // A read still in flight at restart belongs to the old region; drop its data.
      if (trigger) discard_q <= pending_q & ~ret;
      else if (ret) discard_q <= 1'b0;
      if (trigger) begin
        start_q <= start_addr;
        end_q   <= end_addr;
        addr_q  <= start_addr;
        playing <= 1'b1;
      end else if (play) begin
        addr_q <= (addr_q == end_q) ? start_q : addr_q + 1'b1;
      end
      if (accept) buf_q <= u8_to_sample(rom_data);
      if (play) out <= buf_q;
      if (finish) begin
        out     <= '0;
        playing <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_sample_player.sv
// Directed + randomized bench for pcm_sample_player with a latency-programmable
// ROM model and a region-level playback model.
module tb_pcm_sample_player;
  import discrete_audio_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          audio_clk_en = 1'b0;
  logic          trigger = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic          rom_valid = 1'b0;
  logic [7:0]    rom_data = 8'h00;
  sample_t       out;
  logic          playing, done, underrun;
  pcm_state_t    state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  pcm_sample_player #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .trigger(trigger),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .out(out), .playing(playing), .done(done), .underrun(underrun), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  logic [7:0]    rom_mem [0:65535];
  int            rom_lat = 2;
  int            cyc = 0;
  logic [AW-1:0] rq_addr[$];
  int            rq_due[$];
  logic [AW-1:0] addr_log[$];
  int            overlap_cnt = 0;
  bit            spur = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rom_rd === 1'b1) begin
      if (rq_addr.size() != 0) overlap_cnt++;
      rq_addr.push_back(rom_addr);
      rq_due.push_back(cyc + rom_lat);
      addr_log.push_back(rom_addr);
    end
    rom_valid = 1'b0;
    rom_data  = 8'h00;
    if (rq_due.size() != 0 && rq_due[0] == cyc) begin
      rom_valid = 1'b1;
      rom_data  = rom_mem[rq_addr[0]];
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else if (spur) begin
      rom_valid = 1'b1;
      rom_data  = 8'hC3;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- playback model ----------------
  sample_t reg_q[$];
  int      m_pos = 0;
  sample_t last_out = '0;
  int      ur_cnt = 0;

  function automatic sample_t conv(input logic [7:0] b);
    return sample_t'((int'(b) - 128) * 256);
  endfunction

  task automatic build(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    reg_q.delete();
    a = s;
    forever begin
      reg_q.push_back(conv(rom_mem[a]));
      if (a == e) break;
      a = a + 1'b1;
    end
    m_pos = 0;
  endtask

  task automatic trig(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit lp,
                      input bit with_en, input string tag);
    build(s, e);
    @(negedge clk);
    start_addr   = s;
    end_addr     = e;
    loop_en      = lp;
    trigger      = 1'b1;
    audio_clk_en = with_en;
    @(negedge clk);
    trigger      = 1'b0;
    audio_clk_en = 1'b0;
    chk({tag, "_playing"}, playing, 1);
    chk({tag, "_out_hold"}, out, last_out);
    if (with_en) chk({tag, "_no_underrun"}, underrun, 0);
  endtask

  task automatic enable(input int gap, input bit may_ur, input string tag, output bit fin);
    sample_t exp;
    repeat (gap) @(negedge clk);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    fin = 1'b0;
    if (may_ur && underrun === 1'b1) begin
      ur_cnt++;
      chk({tag, "_underrun_hold"}, out, last_out);
    end else begin
      chk({tag, "_underrun"}, underrun, 0);
      if (m_pos < reg_q.size()) begin
        exp = reg_q[m_pos];
        m_pos++;
        if (m_pos == reg_q.size() && loop_en) m_pos = 0;
        chk({tag, "_out"}, out, exp);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_playing"}, playing, 1);
      end else begin
        exp = '0;
        fin = 1'b1;
        chk({tag, "_end_out"}, out, 0);
        chk({tag, "_end_done"}, done, 1);
        chk({tag, "_end_playing"}, playing, 0);
      end
      last_out = exp;
    end
  endtask

  task automatic run_until_done(input int gap, input bit may_ur, input string tag, input int budget);
    bit fin;
    int n;
    fin = 1'b0;
    n = 0;
    while (!fin && n < budget) begin
      enable(gap, may_ur, tag, fin);
      n++;
    end
    chk({tag, "_finished"}, fin, 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit            f;
    logic [AW-1:0] ea [4];
    logic [AW-1:0] s, e;
    int            len;

    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'h80;
    rom_mem[0] = 8'h00; rom_mem[1] = 8'h80; rom_mem[2] = 8'hFF; rom_mem[3] = 8'h40;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_rom_rd", rom_rd, 0);
    chk("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: one-shot, latency 2, a stray beat while a sample is buffered
    rom_lat = 2;
    trig(16'h0000, 16'h0003, 1'b0, 1'b0, "t1_trig");
    repeat (8) @(negedge clk);
    #2 spur = 1'b1;
    @(negedge clk);
    #2 spur = 1'b0;
    run_until_done(9, 1'b0, "t1", 8);

    // 2: trigger+enable together, then looping for 10 enables
    trig(16'h0000, 16'h0003, 1'b1, 1'b1, "t2_trig");
    for (int i = 0; i < 10; i++) enable(9, 1'b0, "t2_loop", f);
    loop_en = 1'b0;
    run_until_done(9, 1'b0, "t2_exit", 8);

    // 3: slow ROM, fast enables
    rom_lat = 30;
    ur_cnt = 0;
    trig(16'h0000, 16'h0003, 1'b0, 1'b0, "t3_trig");
    run_until_done(19, 1'b1, "t3", 30);
    chk("t3_underrun_seen", (ur_cnt > 0), 1);

    // 4: retrigger while a read is outstanding
    rom_lat = 10;
    trig(16'h0000, 16'h0003, 1'b0, 1'b0, "t4_trig_a");
    repeat (2) @(negedge clk);
    addr_log.delete();
    trig(16'h0002, 16'h0003, 1'b0, 1'b0, "t4_trig_b");
    run_until_done(40, 1'b0, "t4", 6);
    chk("t4_reads", addr_log.size(), 2);
    chk("t4_first_addr", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 2);

    // 5: region wrapping through the top of the address space
    rom_lat = 3;
    rom_mem[16'hFFFE] = 8'($urandom_range(0, 255));
    rom_mem[16'hFFFF] = 8'($urandom_range(0, 255));
    rom_mem[16'h0000] = 8'($urandom_range(0, 255));
    rom_mem[16'h0001] = 8'($urandom_range(0, 255));
    ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;
    addr_log.delete();
    trig(16'hFFFE, 16'h0001, 1'b0, 1'b0, "t5_trig");
    run_until_done(10, 1'b0, "t5", 8);
    chk("t5_reads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t5_addr%0d", i), (i < addr_log.size()) ? int'(addr_log[i]) : -1, int'(ea[i]));

    // randomized regions, including single-sample ones
    for (int r = 0; r < 6; r++) begin
      s = 16'($urandom_range(0, 65535));
      len = $urandom_range(1, 6);
      e = s + 16'(len - 1);
      for (int k = 0; k < len; k++) rom_mem[16'(s + 16'(k))] = 8'($urandom_range(0, 255));
      rom_lat = $urandom_range(1, 6);
      trig(s, e, 1'b0, 1'b0, "rnd_trig");
      run_until_done($urandom_range(10, 14), 1'b0, "rnd", 10);
    end

    // 6: asynchronous reset mid-playback with a read outstanding
    rom_mem[0] = 8'h00; rom_mem[1] = 8'h80; rom_mem[2] = 8'hFF; rom_mem[3] = 8'h40;
    rom_lat = 8;
    trig(16'h0000, 16'h0003, 1'b0, 1'b0, "t6_trig");
    enable(12, 1'b0, "t6", f);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_out", out, 0);
    chk("t6_rst_playing", playing, 0);
    chk("t6_rst_rom_rd", rom_rd, 0);
    @(negedge clk);
    reset = 1'b0;
    last_out = '0;
    repeat (20) @(negedge clk);
    chk("t6_late_out", out, 0);
    chk("t6_late_playing", playing, 0);
    chk("t6_idle", state_dbg, IDLE);
    @(negedge clk);
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    chk("t6_idle_en_out", out, 0);
    chk("t6_idle_en_underrun", underrun, 0);

    chk("single_outstanding_read", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
